// File: rtl/fp_pkg.sv
// Shared FP32 field layout, constants and accumulator FSM state encoding.
// ST_WAIT is only present when FP_ACC_PIPE_EN is defined.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
`ifdef FP_ACC_PIPE_EN
        ST_WAIT = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp_accumulator_adder.sv
// Combinational FP32 adder, round-to-nearest-even, denormal inputs/outputs flushed to zero.
// A zero (or denormal) operand returns the other operand unchanged; no handshake.
module Adder
    import fp_pkg::*;
(
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [31:0] result
);

    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  dexp;
    logic [26:0] ma;
    logic [26:0] mb;
    logic [26:0] mb_sh;
    logic [26:0] diff;
    logic [26:0] m;
    logic [27:0] s;
    logic [24:0] rnd;
    logic        up;
    logic        found;
    logic        nan1;
    logic        nan2;
    logic        inf1;
    logic        inf2;
    int          e;
    int          lz;

    always_comb begin
        a      = data1;
        b      = data2;
        mb_sh  = '0;
        diff   = '0;
        s      = '0;
        m      = '0;
        rnd    = '0;
        up     = 1'b0;
        found  = 1'b0;
        lz     = 0;
        result = FP_ZERO;

        // Order operands so that a has the larger magnitude.
        if (data2[EXP_MSB:0] > data1[EXP_MSB:0]) begin
            a = data2;
            b = data1;
        end
        sa   = a[SIGN_BIT];
        sb   = b[SIGN_BIT];
        ea   = fp_exp(a);
        eb   = fp_exp(b);
        ma   = {1'b1, fp_man(a), 3'b000};
        mb   = {1'b1, fp_man(b), 3'b000};
        dexp = ea - eb;
        e    = int'(ea);

        // Align with guard/round bits; everything shifted out collapses into the sticky bit.
        if (dexp >= 8'd27) begin
            mb_sh = 27'd1;
        end else begin
            mb_sh = (mb >> dexp) | {26'd0, |(mb & ((27'd1 << dexp) - 27'd1))};
        end

        if (sa == sb) begin
            s = {1'b0, ma} + {1'b0, mb_sh};
            if (s[27]) begin
                m = s[27:1] | {26'd0, s[0]};
                e = e + 1;
            end else begin
                m = s[26:0];
            end
        end else begin
            diff = ma - mb_sh;
            for (int i = 26; i >= 0; i--) begin
                if (!found && diff[i]) begin
                    lz    = 26 - i;
                    found = 1'b1;
                end
            end
            m = diff << lz;
            e = e - lz;
        end

        up  = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            e = e + 1;
        end

        if (sa != sb && diff == '0) begin
            result = FP_ZERO;
        end else if (e >= 255) begin
            result = {sa, EXP_MAX, {MAN_W{1'b0}}};
        end else if (e <= 0) begin
            result = {sa, 31'd0};
        end else begin
            result = {sa, e[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
        end

        nan1 = (fp_exp(data1) == EXP_MAX) && (fp_man(data1) != '0);
        nan2 = (fp_exp(data2) == EXP_MAX) && (fp_man(data2) != '0);
        inf1 = (fp_exp(data1) == EXP_MAX) && (fp_man(data1) == '0);
        inf2 = (fp_exp(data2) == EXP_MAX) && (fp_man(data2) == '0);

        if (nan1 || nan2 || (inf1 && inf2 && (data1[SIGN_BIT] != data2[SIGN_BIT]))) begin
            result = FP_QNAN;
        end else if (inf1) begin
            result = data1;
        end else if (inf2) begin
            result = data2;
        end else if (fp_exp(data1) == 8'd0) begin
            result = data2;
        end else if (fp_exp(data2) == 8'd0) begin
            result = data1;
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Sums len FP32 elements; 1 elem/cycle, result 1 cycle after last transfer (FP_ACC_PIPE_EN: 1 elem/2 cycles, 2 cycles).
// in_ready drops outside ACC; the result is held in DONE until out_ready.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      sum_q;
    logic [31:0]      add_res;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_q;
    logic             xfer;
    logic             at_last;
`ifdef FP_ACC_PIPE_EN
    logic [31:0]      add_q;
`endif

    Adder u_adder (
        .data1  (sum_q),
        .data2  (in_data),
        .result (add_res)
    );

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign xfer     = in_valid && in_ready;
    assign out_data = sum_q;

`ifdef FP_ACC_PIPE_EN
    // The counter has already advanced at the transfer by the time WAIT evaluates this.
    assign at_last = (cnt_q == len_q);
`else
    assign at_last = (cnt_inc == len_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef FP_ACC_PIPE_EN
                    state_nxt = ST_WAIT;
`else
                    state_nxt = at_last ? ST_DONE : ST_ACC;
`endif
                end
            end
`ifdef FP_ACC_PIPE_EN
            ST_WAIT: begin
                state_nxt = at_last ? ST_DONE : ST_ACC;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= FP_ZERO;
            cnt_q <= '0;
            len_q <= '0;
`ifdef FP_ACC_PIPE_EN
            add_q <= FP_ZERO;
`endif
        end else begin
            if (state == ST_IDLE && start) begin
                len_q <= len;
                sum_q <= FP_ZERO;
                cnt_q <= '0;
            end
            if (xfer) begin
                cnt_q <= cnt_inc;
`ifdef FP_ACC_PIPE_EN
                add_q <= add_res;
`else
                sum_q <= add_res;
`endif
            end
`ifdef FP_ACC_PIPE_EN
            if (state == ST_WAIT) begin
                sum_q <= add_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed scenarios plus random runs scored against an exact half-integer model.
module tb_fp_accumulator;

    localparam int CNT_W = 8;
`ifdef FP_ACC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             start     = 1'b0;
    logic [CNT_W-1:0] len       = '0;
    logic             in_valid  = 1'b0;
    logic [31:0]      in_data   = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Exact FP32 encoding of h/2 for |h| < 2^24.
    function automatic logic [31:0] h2f(input int h);
        int          mag;
        int          p;
        logic [31:0] r;
        if (h == 0) return 32'h0;
        mag = (h < 0) ? -h : h;
        p   = 0;
        for (int i = 0; i < 31; i++) begin
            if (mag >= (1 << i)) p = i;
        end
        r[31]    = (h < 0);
        r[30:23] = 8'(p - 1 + 127);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        len   = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_valid();
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 600) begin
            tick();
            cyc++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ack_idle_busy", 32'(busy), 32'd0);
        check("ack_idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int sum_h;
        int h;
        int n;

        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // 1.0 + 2.0 + 3.0 back to back
        do_start(3);
        check("acc_in_ready", 32'(in_ready), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        push(32'h3F80_0000);
        push(32'h4000_0000);
        push(32'h4040_0000);
`ifdef FP_ACC_PIPE_EN
        check("latency_early", 32'(out_valid), 32'd0);
        tick();
`endif
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("sum3_out_data", out_data, 32'h40C0_0000);
        ack();

        // len = 0 goes straight to DONE
        check("len0_pre_in_ready", 32'(in_ready), 32'd0);
        do_start(0);
        check("len0_out_valid", 32'(out_valid), 32'd1);
        check("len0_out_data", out_data, 32'h0);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        ack();

        // gaps between elements: 2.0 then -0.5
        do_start(2);
        push(32'h4000_0000);
        repeat (3) begin
            tick();
            check("gap_in_ready", 32'(in_ready), 32'd1);
            check("gap_no_out", 32'(out_valid), 32'd0);
        end
        push(32'hBF00_0000);
        wait_valid();
        check("gap_out_data", out_data, 32'h3FC0_0000);

        // hold in DONE for 5 cycles; a start pulse here is ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = CNT_W'(9);
            tick();
            start = 1'b0;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", out_data, 32'h3FC0_0000);
        end
        ack();
        tick();
        check("done_start_ignored", 32'(busy), 32'd0);

        // start with a different len while in ACC is ignored
        do_start(4);
        sum_h = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                len   = CNT_W'(1);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            h = int'($urandom_range(0, 60)) - 30;
            sum_h += h;
            push(h2f(h));
            if (k < 3) check("acc_start_not_done", 32'(out_valid), 32'd0);
        end
        wait_valid();
        check("acc_start_sum", out_data, h2f(sum_h));
        ack();

        // reset after 1 of 4 elements
        do_start(4);
        push(32'h3F80_0000);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_sum", out_data, 32'h0);
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("abort_no_out", 32'(out_valid), 32'd0);
        end
        do_start(1);
        push(32'h3F80_0000);
        wait_valid();
        check("fresh_len1", out_data, 32'h3F80_0000);
        ack();

        // random lengths, gaps and consumer delay
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 10));
            do_start(n);
            sum_h = 0;
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                h = int'($urandom_range(0, 60)) - 30;
                sum_h += h;
                push(h2f(h));
            end
            wait_valid();
            check("rand_sum", out_data, h2f(sum_h));
            repeat ($urandom_range(0, 3)) tick();
            check("rand_hold", out_data, h2f(sum_h));
            ack();
        end

        // longest supported run
        do_start(255);
        sum_h = 0;
        for (int k = 0; k < 255; k++) begin
            h = int'($urandom_range(0, 40)) - 20;
            sum_h += h;
            push(h2f(h));
        end
        wait_valid();
        check("len255_sum", out_data, h2f(sum_h));
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
